// File: rtl/ddr_init_if.sv
// Command/status bundle between the DDR init sequencer (master) and the signal-generate stage and arbiter (slave).
// DDR_INIT_REINIT_EN adds the init_restart request.
interface ddr_init_if #(
    parameter int ADDR_W = 13
);
    logic              init_start;
`ifdef DDR_INIT_REINIT_EN
    logic              init_restart;
`endif
    logic [2:0]        cmd;
    logic [1:0]        ba;
    logic [ADDR_W-1:0] addr;
    logic              cke;
    logic              busy;
    logic              init_done;
    logic [3:0]        state;

    modport master (
        input  init_start,
`ifdef DDR_INIT_REINIT_EN
        input  init_restart,
`endif
        output cmd, ba, addr, cke, busy, init_done, state
    );

    modport slave (
        output init_start,
`ifdef DDR_INIT_REINIT_EN
        output init_restart,
`endif
        input  cmd, ba, addr, cke, busy, init_done, state
    );
endinterface

// File: rtl/ddr_init_seq.sv
// DDR SDRAM power-up init sequencer: CKE hold-off, PRE, EMRS, MRS+DLL reset, PRE, N x AREF, MRS, DLL lock wait.
// Optional macro DDR_INIT_REINIT_EN: init_restart in DONE reruns the command sequence without the power-up wait.
// state | meaning: 0 IDLE | 1 PWRUP cke low | 2 CKE_NOP | 3 PRE1 | 4 EMRS | 5 MRS_DLL | 6 PRE2
//                  7 AREF | 8 MRS | 9 WAIT timing gap | 10 DLL_WAIT | 11 DONE
module ddr_init_seq #(
    parameter int                PWRUP_CYC    = 26667,
    parameter int                T_RP_CYC     = 3,
    parameter int                T_MRD_CYC    = 2,
    parameter int                T_RFC_CYC    = 10,
    parameter int                N_AUTO_REF   = 2,
    parameter int                DLL_LOCK_CYC = 200,
    parameter int                ADDR_W       = 13,
    parameter logic [ADDR_W-1:0] MR_VAL       = ADDR_W'(13'h0022),
    parameter logic [ADDR_W-1:0] EMR_VAL      = '0
) (
    input logic        clk,
    input logic        rst_n,
    ddr_init_if.master bus
);
    localparam logic [3:0] IDLE = 4'd0, PWRUP = 4'd1, CKE_NOP = 4'd2, PRE1 = 4'd3,
                           EMRS = 4'd4, MRS_DLL = 4'd5, PRE2 = 4'd6, AREF = 4'd7,
                           MRS = 4'd8, WAIT = 4'd9, DLL_WAIT = 4'd10, DONE = 4'd11;

    localparam logic [2:0] CMD_NOP = 3'b111, CMD_PRE = 3'b010, CMD_AREF = 3'b001, CMD_LMR = 3'b000;

    localparam int T_MAX0 = (T_RP_CYC > T_MRD_CYC) ? T_RP_CYC : T_MRD_CYC;
    localparam int T_MAX  = (T_MAX0 > T_RFC_CYC) ? T_MAX0 : T_RFC_CYC;
    localparam int TMR_W  = $clog2(T_MAX) + 1;
    localparam int PWR_W  = (PWRUP_CYC < 1) ? 1 : $clog2(PWRUP_CYC + 1);
    localparam int DLL_W  = (DLL_LOCK_CYC < 1) ? 1 : $clog2(DLL_LOCK_CYC + 1);
    localparam int REF_W  = $clog2(N_AUTO_REF + 1);

    logic [3:0]        state_q, state_nxt, ret_q, ret_nxt, follow;
    logic [TMR_W-1:0]  timer_q, timer_nxt;
    logic [PWR_W-1:0]  pwr_q, pwr_nxt;
    logic [REF_W-1:0]  aref_q, aref_nxt;
    logic [DLL_W-1:0]  dll_q;
    logic              dll_run, dll_ok, issue;
    int                t_cyc;
    logic [2:0]        cmd_q, cmd_nxt;
    logic [1:0]        ba_q, ba_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic              cke_q, busy_q, done_q;

    // dll_ok looks one cycle ahead so DONE is entered in the first cycle the count reaches DLL_LOCK_CYC
    assign dll_ok = dll_run && (({1'b0, dll_q} + 1'b1) >= (DLL_W + 1)'(DLL_LOCK_CYC));

    function automatic logic [3:0] resolve(input logic [3:0] r, input logic ok);
        return (r == DLL_WAIT && ok) ? DONE : r;
    endfunction

    always_comb begin
        state_nxt = state_q;
        timer_nxt = timer_q;
        ret_nxt   = ret_q;
        pwr_nxt   = pwr_q;
        aref_nxt  = aref_q;
        issue     = 1'b0;
        t_cyc     = 0;
        follow    = IDLE;
        case (state_q)
            IDLE: if (bus.init_start) begin
                state_nxt = PWRUP;
                pwr_nxt   = PWR_W'(PWRUP_CYC);
            end
            PWRUP: if (pwr_q <= PWR_W'(1)) state_nxt = CKE_NOP;
                   else pwr_nxt = pwr_q - 1'b1;
            CKE_NOP: begin
                state_nxt = PRE1;
                aref_nxt  = '0;
            end
            PRE1:    begin issue = 1'b1; t_cyc = T_RP_CYC;  follow = EMRS;     end
            EMRS:    begin issue = 1'b1; t_cyc = T_MRD_CYC; follow = MRS_DLL;  end
            MRS_DLL: begin issue = 1'b1; t_cyc = T_MRD_CYC; follow = PRE2;     end
            PRE2:    begin issue = 1'b1; t_cyc = T_RP_CYC;  follow = AREF;     end
            AREF: begin
                issue    = 1'b1;
                t_cyc    = T_RFC_CYC;
                aref_nxt = aref_q + 1'b1;
                follow   = (aref_q == REF_W'(N_AUTO_REF - 1)) ? MRS : AREF;
            end
            MRS:     begin issue = 1'b1; t_cyc = T_MRD_CYC; follow = DLL_WAIT; end
            WAIT: if (timer_q <= TMR_W'(1)) state_nxt = resolve(ret_q, dll_ok);
                  else timer_nxt = timer_q - 1'b1;
            DLL_WAIT: if (dll_ok) state_nxt = DONE;
`ifdef DDR_INIT_REINIT_EN
            DONE: if (bus.init_restart) state_nxt = CKE_NOP;
`else
            DONE: state_nxt = DONE;
`endif
            default: state_nxt = IDLE;
        endcase
        // a gap of one cycle needs no WAIT visit; longer gaps park in WAIT for T-1 cycles
        if (issue) begin
            if (t_cyc <= 1) state_nxt = resolve(follow, dll_ok);
            else begin
                state_nxt = WAIT;
                timer_nxt = TMR_W'(t_cyc - 1);
                ret_nxt   = follow;
            end
        end
    end

    always_comb begin
        cmd_nxt  = CMD_NOP;
        ba_nxt   = 2'b00;
        addr_nxt = '0;
        case (state_nxt)
            PRE1, PRE2: begin cmd_nxt = CMD_PRE; addr_nxt[10] = 1'b1; end
            EMRS:       begin cmd_nxt = CMD_LMR; ba_nxt = 2'b01; addr_nxt = EMR_VAL; end
            MRS_DLL:    begin cmd_nxt = CMD_LMR; addr_nxt = MR_VAL; addr_nxt[8] = 1'b1; end
            AREF:       cmd_nxt = CMD_AREF;
            MRS:        begin cmd_nxt = CMD_LMR; addr_nxt = MR_VAL; end
            default:    cmd_nxt = CMD_NOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ret_q   <= IDLE;
            timer_q <= '0;
            pwr_q   <= '0;
            aref_q  <= '0;
            dll_q   <= '0;
            dll_run <= 1'b0;
            cmd_q   <= CMD_NOP;
            ba_q    <= 2'b00;
            addr_q  <= '0;
            cke_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            ret_q   <= ret_nxt;
            timer_q <= timer_nxt;
            pwr_q   <= pwr_nxt;
            aref_q  <= aref_nxt;
            if (state_q == MRS_DLL) begin
                dll_q   <= DLL_W'(1);
                dll_run <= 1'b1;
            end else if (dll_run && dll_q != DLL_W'(DLL_LOCK_CYC)) begin
                dll_q <= dll_q + 1'b1;
            end
            cmd_q  <= cmd_nxt;
            ba_q   <= ba_nxt;
            addr_q <= addr_nxt;
            cke_q  <= cke_q | (state_nxt == CKE_NOP);
            busy_q <= (state_nxt != IDLE) && (state_nxt != DONE);
            done_q <= (state_nxt == DONE);
        end
    end

    assign bus.cmd       = cmd_q;
    assign bus.ba        = ba_q;
    assign bus.addr      = addr_q;
    assign bus.cke       = cke_q;
    assign bus.busy      = busy_q;
    assign bus.init_done = done_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_ddr_init_seq.sv
// Directed bench for ddr_init_seq: three instances (baseline, DLL-light, four refreshes) logged per cycle and
// compared against hand-derived command timelines; reinit is exercised when DDR_INIT_REINIT_EN is defined.
module tb_ddr_init_seq;
    localparam int LOG_N = 400;

    typedef struct packed {
        logic        cke;
        logic        busy;
        logic        done;
        logic [1:0]  ba;
        logic [2:0]  cmd;
        logic [12:0] addr;
    } smp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_start = 1'b0;
`ifdef DDR_INIT_REINIT_EN
    logic init_restart = 1'b0;
`endif
    int   n_run = 0;
    int   n_fail = 0;
    smp_t lg [3][LOG_N];

    always #5 clk = ~clk;

    ddr_init_if #(.ADDR_W(13)) if_a ();
    ddr_init_if #(.ADDR_W(13)) if_b ();
    ddr_init_if #(.ADDR_W(13)) if_c ();

    assign if_a.init_start = init_start;
    assign if_b.init_start = init_start;
    assign if_c.init_start = init_start;
`ifdef DDR_INIT_REINIT_EN
    assign if_a.init_restart = init_restart;
    assign if_b.init_restart = init_restart;
    assign if_c.init_restart = init_restart;
`endif

    ddr_init_seq #(.PWRUP_CYC(10), .T_RP_CYC(3), .T_MRD_CYC(2), .T_RFC_CYC(10),
                   .N_AUTO_REF(2), .DLL_LOCK_CYC(200)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    ddr_init_seq #(.PWRUP_CYC(10), .T_RP_CYC(3), .T_MRD_CYC(2), .T_RFC_CYC(10),
                   .N_AUTO_REF(2), .DLL_LOCK_CYC(20)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    ddr_init_seq #(.PWRUP_CYC(10), .T_RP_CYC(3), .T_MRD_CYC(2), .T_RFC_CYC(10),
                   .N_AUTO_REF(4), .DLL_LOCK_CYC(200)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    task automatic chk(input string tag, input int got, input int exp);
        n_run++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic start();
        @(negedge clk);
        rst_n      = 1'b1;
        init_start = 1'b1;
    endtask

    // index 0 is the cycle right after the start (or restart) request was sampled
    task automatic capture();
        for (int i = 0; i < LOG_N; i++) begin
            @(negedge clk);
`ifdef DDR_INIT_REINIT_EN
            if (i == 0) init_restart = 1'b0;
`endif
            lg[0][i] = {if_a.cke, if_a.busy, if_a.init_done, if_a.ba, if_a.cmd, if_a.addr};
            lg[1][i] = {if_b.cke, if_b.busy, if_b.init_done, if_b.ba, if_b.cmd, if_b.addr};
            lg[2][i] = {if_c.cke, if_c.busy, if_c.init_done, if_c.ba, if_c.cmd, if_c.addr};
        end
    endtask

    task automatic analyze(input int d, input int n_aref, input int exp_done, input int exp_p0, input string nm);
        int et[12], ec[12], eba[12], ead[12];
        int gt[12], gc[12], gba[12], gad[12];
        int n_exp, k, p0, cke0, first_cke, nop_bad, done_at, busy_at, drop;
        smp_t s;
        for (int j = 0; j < 12; j++) begin
            gt[j] = -1; gc[j] = -1; gba[j] = -1; gad[j] = -1;
            et[j] = 0;  ec[j] = 7;  eba[j] = 0;  ead[j] = 0;
        end
        et[0] = 0; ec[0] = 2; ead[0] = 'h400;
        et[1] = 3; ec[1] = 0; eba[1] = 1;
        et[2] = 5; ec[2] = 0; ead[2] = 'h122;
        et[3] = 7; ec[3] = 2; ead[3] = 'h400;
        for (int j = 0; j < n_aref; j++) begin
            et[4 + j] = 10 + 10 * j; ec[4 + j] = 1;
        end
        et[4 + n_aref] = 10 + 10 * n_aref; ec[4 + n_aref] = 0; ead[4 + n_aref] = 'h22;
        n_exp = 5 + n_aref;

        k = 0; p0 = -1; cke0 = 0; first_cke = -1; nop_bad = 0; done_at = -1; busy_at = -1; drop = 0;
        for (int i = 0; i < LOG_N; i++) begin
            s = lg[d][i];
            if (!s.cke) cke0++;
            else if (first_cke < 0) first_cke = i;
            if (s.cmd != 3'b111) begin
                if (p0 < 0) p0 = i;
                if (k < 12) begin
                    gt[k] = i - p0; gc[k] = int'(s.cmd); gba[k] = int'(s.ba); gad[k] = int'(s.addr);
                end
                k++;
            end else if (s.ba != 2'b00 || s.addr != 13'h0) begin
                nop_bad++;
            end
            if (s.done && done_at < 0) done_at = i - exp_p0;
            if (done_at >= 0 && !s.done) drop++;
            if (!s.busy && i > 0 && busy_at < 0) busy_at = i - exp_p0;
        end

        chk({nm, ".first_pre"}, p0, exp_p0);
        chk({nm, ".cke_low_cycles"}, cke0, exp_p0 - 1);
        chk({nm, ".cke_rise"}, first_cke, exp_p0 - 1);
        chk({nm, ".n_cmds"}, k, n_exp);
        for (int j = 0; j < n_exp; j++) begin
            chk($sformatf("%s.c%0d_time", nm, j), gt[j], et[j]);
            chk($sformatf("%s.c%0d_cmd", nm, j), gc[j], ec[j]);
            chk($sformatf("%s.c%0d_ba", nm, j), gba[j], eba[j]);
            chk($sformatf("%s.c%0d_addr", nm, j), gad[j], ead[j]);
        end
        chk({nm, ".nop_fields"}, nop_bad, 0);
        chk({nm, ".busy_first"}, int'(lg[d][0].busy), 1);
        chk({nm, ".done_first"}, int'(lg[d][0].done), 0);
        chk({nm, ".done_rise"}, done_at, exp_done);
        chk({nm, ".busy_fall"}, busy_at, exp_done);
        chk({nm, ".done_sticky"}, drop, 0);
    endtask

    initial begin
        int bad;
        repeat (3) @(negedge clk);
        chk("rst.state", int'(if_a.state), 0);
        chk("rst.cmd", int'(if_a.cmd), 7);
        chk("rst.ba", int'(if_a.ba), 0);
        chk("rst.addr", int'(if_a.addr), 0);
        chk("rst.cke", int'(if_a.cke), 0);
        chk("rst.busy", int'(if_a.busy), 0);
        chk("rst.done", int'(if_a.init_done), 0);

        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (if_a.state != 4'd0 || if_a.cke || if_a.cmd != 3'b111 || if_a.busy || if_a.init_done) bad++;
            if (if_c.state != 4'd0 || if_c.cke || if_c.cmd != 3'b111) bad++;
        end
        chk("idle_hold", bad, 0);

        start();
        capture();
        analyze(0, 2, 205, 11, "base");
        analyze(1, 2, 32, 11, "dll20");
        analyze(2, 4, 205, 11, "aref4");

        @(negedge clk);
        rst_n      = 1'b0;
        init_start = 1'b0;
        start();
        repeat (27) @(negedge clk);
        chk("pre_rst.state", int'(if_a.state), 9);
        chk("pre_rst.cke", int'(if_a.cke), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst.cke", int'(if_a.cke), 0);
        chk("async_rst.cmd", int'(if_a.cmd), 7);
        chk("async_rst.state", int'(if_a.state), 0);
        chk("async_rst.busy", int'(if_a.busy), 0);
        start();
        capture();
        analyze(0, 2, 205, 11, "rerun");

`ifdef DDR_INIT_REINIT_EN
        chk("pre_reinit.done", int'(if_a.init_done), 1);
        @(negedge clk);
        init_restart = 1'b1;
        capture();
        analyze(0, 2, 205, 1, "reinit_a");
        analyze(1, 2, 32, 1, "reinit_b");
        analyze(2, 4, 205, 1, "reinit_c");
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
